dot_product_memory_reader: RTL and testbench

Operand fetch engine at the input end of the dot-product datapath: on a start pulse it reads `length` consecutive address pairs from the two operand memories (A and B, shared read address, one-cycle read latency). It buffers the returned pairs in a small FIFO and presents them to the dot-product unit over a valid/ready stream. The final element is tagged `out_last`. It is the read-side counterpart of the result memory writer: it feeds the dot-product core, and the writer drains it.

---
 rtl/dot_product_memory_reader_if.sv | 25 ++
 rtl/dot_product_memory_reader.sv | 124 ++++++++++++
 tb/tb_dot_product_memory_reader.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/dot_product_memory_reader_if.sv
// rtl/dot_product_memory_reader_if.sv - operand memory read bus and operand pair stream
interface dot_product_memory_reader_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32
);
    logic [ADDRESS_WIDTH-1:0] rdaddr;
    logic                     rden;
    logic [DATA_WIDTH-1:0]    rddata_a;
    logic [DATA_WIDTH-1:0]    rddata_b;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_WIDTH-1:0]    out_a;
    logic [DATA_WIDTH-1:0]    out_b;
    logic                     out_last;

    modport master (
        output rdaddr, rden, out_valid, out_a, out_b, out_last,
        input  rddata_a, rddata_b, out_ready
    );

    modport slave (
        input  rdaddr, rden, out_valid, out_a, out_b, out_last,
        output rddata_a, rddata_b, out_ready
    );
endinterface

// File: rtl/dot_product_memory_reader.sv
// rtl/dot_product_memory_reader.sv - operand pair fetch engine with output FIFO
module dot_product_memory_reader #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] base_addr,
    input  logic [ADDRESS_WIDTH:0]   length,
    output logic                     busy,
    output logic                     done,
    dot_product_memory_reader_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t state_q, state_d;

    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [ADDRESS_WIDTH:0]   len_q;
    logic [ADDRESS_WIDTH:0]   issue_cnt;
    logic                     rd_valid_q;
    logic                     rd_last_q;

    logic [DATA_WIDTH-1:0] fifo_a    [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_b    [FIFO_DEPTH];
    logic                  fifo_last [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [PTR_W:0]        count;

    logic issue, is_last_issue, accept_start, push, pop, fifo_valid, has_room;

    assign fifo_valid    = (count != '0);
    assign pop           = fifo_valid && bus.out_ready;
    assign push          = rd_valid_q;
    assign is_last_issue = (issue_cnt == len_q - (ADDRESS_WIDTH+1)'(1));
    assign accept_start  = start && ((state_q == IDLE) || (state_q == DONE));
    // Counting the in-flight read reserves its FIFO slot before the data lands.
    assign has_room      = (({1'b0, count} + {{(PTR_W+1){1'b0}}, rd_valid_q})
                            < (PTR_W+2)'(FIFO_DEPTH));

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = (length == '0) ? DONE : FETCH;
            end
            FETCH: begin
                busy = 1'b1;
                if (has_room) begin
                    issue = 1'b1;
                    if (is_last_issue) state_d = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (pop && fifo_last[rd_ptr]) state_d = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_d = (length == '0) ? DONE : FETCH;
                else       state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            addr_q     <= '0;
            len_q      <= '0;
            issue_cnt  <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            rd_valid_q <= issue;
            rd_last_q  <= issue && is_last_issue;
            if (accept_start) begin
                addr_q    <= base_addr;
                len_q     <= length;
                issue_cnt <= '0;
            end else if (issue) begin
                addr_q    <= addr_q + ADDRESS_WIDTH'(1);
                issue_cnt <= issue_cnt + (ADDRESS_WIDTH+1)'(1);
            end
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a[wr_ptr]    <= bus.rddata_a;
            fifo_b[wr_ptr]    <= bus.rddata_b;
            fifo_last[wr_ptr] <= rd_last_q;
        end
    end

    assign bus.rden      = issue;
    assign bus.rdaddr    = addr_q;
    assign bus.out_valid = fifo_valid;
    assign bus.out_a     = fifo_valid ? fifo_a[rd_ptr] : '0;
    assign bus.out_b     = fifo_valid ? fifo_b[rd_ptr] : '0;
    assign bus.out_last  = fifo_valid ? fifo_last[rd_ptr] : 1'b0;
endmodule

// File: tb/tb_dot_product_memory_reader.sv
// tb/tb_dot_product_memory_reader.sv - directed job table plus reset and restart sequences
module tb_dot_product_memory_reader;
    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic [7:0] base_addr;
    logic [8:0] length;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    dot_product_memory_reader_if #(.ADDRESS_WIDTH(8), .DATA_WIDTH(32)) bus ();

    dot_product_memory_reader #(
        .ADDRESS_WIDTH(8), .DATA_WIDTH(32), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
        .length(length), .busy(busy), .done(done), .bus(bus)
    );

    // Memory A[i]=i, B[i]=0x100+i, one-cycle read latency.
    always @(posedge clk) begin
        if (bus.rden) begin
            bus.rddata_a <= {24'h0, bus.rdaddr};
            bus.rddata_b <= 32'h100 + {24'h0, bus.rdaddr};
        end
    end

    int n_asserts = 0;
    int n_fail    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rdaddr"}, bus.rdaddr, 0);
        chk({tag, "_rden"}, bus.rden, 0);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_out_a"}, bus.out_a, 0);
        chk({tag, "_out_b"}, bus.out_b, 0);
        chk({tag, "_out_last"}, bus.out_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // mode 0: ready high; 1: ready low in t+2..t+12; 2: second start at t+3
    typedef struct {
        logic [7:0] base;
        logic [8:0] len;
        int         mode;
        int         exp_n;
        logic [7:0] exp_last_a;
        int         exp_done;
        bit         chain;
    } vec_t;

    task automatic run_job(input vec_t v, input bit prestarted, input bit has_next, input vec_t nv);
        int n_out = 0, n_issue = 0, done_k = -1, first_valid_k = -1, first_issue_k = -1, zero_viol = 0;
        logic [7:0] ea;
        logic [7:0] last_a = 8'h0;
        if (!prestarted) begin
            @(posedge clk); #1;
            start = 1'b1; base_addr = v.base; length = v.len;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; base_addr = 8'hAA; length = 9'd5;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (k == 1) chk("busy_after_start", busy, (v.len != 0));
            if (bus.rden) begin
                if (n_issue == 0) first_issue_k = k;
                ea = v.base + n_issue[7:0];
                chk("issue_addr", bus.rdaddr, ea);
                n_issue++;
            end
            if (!bus.out_valid && (bus.out_a != 0 || bus.out_b != 0 || bus.out_last)) zero_viol++;
            if (bus.out_valid && first_valid_k < 0) first_valid_k = k;
            if (v.mode == 1 && k == 12) begin
                chk("bp_head_valid", bus.out_valid, 1);
                chk("bp_head_a", bus.out_a, v.base);
                chk("bp_issues", n_issue, 4);
            end
            if (bus.out_valid && bus.out_ready) begin
                ea = v.base + n_out[7:0];
                chk("out_a", bus.out_a, {24'h0, ea});
                chk("out_b", bus.out_b, 32'h100 + {24'h0, ea});
                chk("out_last", bus.out_last, (n_out == v.exp_n - 1));
                last_a = bus.out_a[7:0];
                n_out++;
            end
            if (done) begin
                done_k = k;
                chk("busy_in_done", busy, 0);
                if (has_next) begin
                    start = 1'b1; base_addr = nv.base; length = nv.len;
                end
                break;
            end
            @(posedge clk); #1;
            bus.out_ready = (v.mode == 1) ? !((k + 1 >= 2) && (k + 1 <= 12)) : 1'b1;
            if (v.mode == 2) begin
                if (k == 2) begin
                    start = 1'b1; base_addr = 8'h40; length = 9'd3;
                end else if (k == 3) begin
                    start = 1'b0; base_addr = 8'hAA; length = 9'd5;
                end
            end
        end
        chk("done_cycle", done_k, v.exp_done);
        chk("n_out", n_out, v.exp_n);
        chk("n_issue", n_issue, v.exp_n);
        chk("zero_mask", zero_viol, 0);
        if (v.exp_n > 0) begin
            chk("last_addr", last_a, v.exp_last_a);
            chk("first_issue_cycle", first_issue_k, 1);
            chk("first_valid_cycle", first_valid_k, 3);
        end else begin
            chk("len0_no_valid", first_valid_k, -1);
        end
    endtask

    vec_t vecs[7];
    vec_t vr;

    initial begin
        vecs[0] = '{8'h10, 9'd4,   0, 4,   8'h13, 7,   1'b0};
        vecs[1] = '{8'h10, 9'd4,   1, 4,   8'h13, 17,  1'b0};
        vecs[2] = '{8'hFE, 9'd4,   0, 4,   8'h01, 7,   1'b0};
        vecs[3] = '{8'h00, 9'd256, 0, 256, 8'hFF, 259, 1'b0};
        vecs[4] = '{8'h00, 9'd0,   0, 0,   8'h00, 1,   1'b0};
        vecs[5] = '{8'h20, 9'd8,   2, 8,   8'h27, 11,  1'b1};
        vecs[6] = '{8'h60, 9'd3,   0, 3,   8'h62, 6,   1'b0};
        vr      = '{8'h50, 9'd2,   0, 2,   8'h51, 5,   1'b0};

        rstn = 1'b0; start = 1'b0; base_addr = 8'h0; length = 9'd0; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check_reset_vals("reset");

        for (int i = 0; i < 7; i++)
            run_job(vecs[i], (i > 0) && vecs[(i + 6) % 7].chain, vecs[i].chain, vecs[(i + 1) % 7]);

        // Mid-job reset with 2 pairs buffered and one read in flight.
        @(posedge clk); #1;
        start = 1'b1; base_addr = 8'h30; length = 9'd8; bus.out_ready = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_reset_valid", bus.out_valid, 1);
        chk("pre_reset_head", bus.out_a, 32'h30);
        @(posedge clk); #1; rstn = 1'b0;
        @(posedge clk); #1; rstn = 1'b1;
        @(negedge clk);
        check_reset_vals("midjob_reset");
        begin
            int stale = 0;
            bus.out_ready = 1'b1;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (bus.out_valid || bus.rden) stale++;
            end
            chk("no_stale_after_reset", stale, 0);
        end
        run_job(vr, 1'b0, 1'b0, vr);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
